// File: rtl/stack_ctrl.sv
// ============================================================================
//  Module   : stack_ctrl
//  Purpose  : Multi-cycle PUSH/POP sequencer driving the register-file write
//             port and the data-memory bus for a downward-growing stack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_ctrl #(
    parameter logic [3:0] SP_ADDR      = 4'd15,
    parameter logic [7:0] STACK_TOP    = 8'd127,
    parameter logic [7:0] STACK_BOTTOM = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op_pop,
    input  logic [7:0] push_data,
    input  logic [3:0] pop_dst,
    input  logic [7:0] sp,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       rf_wr_en,
    output logic [3:0] rf_addr,
    output logic [7:0] rf_wr_data,
    output logic [7:0] mem_addr,
    output logic       mem_wr,
    output logic [7:0] mem_wr_data,
    output logic       mem_rd,
    input  logic [7:0] mem_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_MEM = 3'd1,
        S_PUSH_SP  = 3'd2,
        S_POP_RD   = 3'd3,
        S_POP_SP   = 3'd4,
        S_POP_WB   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sp_q,    sp_d;
    logic [7:0] data_q,  data_d;
    logic [3:0] dst_q,   dst_d;
    logic [7:0] pop_q,   pop_d;
    logic       err_q,   err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sp_q    <= 8'd0;
            data_q  <= 8'd0;
            dst_q   <= 4'd0;
            pop_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            data_q  <= data_d;
            dst_q   <= dst_d;
            pop_q   <= pop_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    // combinationally; the one exception, the IDLE accept, drives no output.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        data_d      = data_q;
        dst_d       = dst_q;
        pop_d       = pop_q;
        err_d       = err_q;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        rf_wr_en    = 1'b0;
        rf_addr     = 4'd0;
        rf_wr_data  = 8'd0;
        mem_addr    = 8'd0;
        mem_wr      = 1'b0;
        mem_wr_data = 8'd0;
        mem_rd      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    sp_d   = sp;
                    data_d = push_data;
                    dst_d  = pop_dst;
                    err_d  = 1'b0;
                    if (op_pop) begin
                        if (sp == STACK_TOP) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_POP_RD;
                        end
                    end else begin
                        if (sp < STACK_BOTTOM) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_PUSH_MEM;
                        end
                    end
                end
            end

            S_PUSH_MEM: begin
                mem_wr      = 1'b1;
                mem_addr    = sp_q;
                mem_wr_data = data_q;
                state_d     = S_PUSH_SP;
            end

            S_PUSH_SP: begin
                rf_wr_en   = 1'b1;
                rf_addr    = SP_ADDR;
                rf_wr_data = sp_q - 8'd1;
                state_d    = S_DONE;
            end

            S_POP_RD: begin
                mem_rd   = 1'b1;
                mem_addr = sp_q + 8'd1;
                state_d  = S_POP_SP;
            end

            S_POP_SP: begin
                // Read data returns one cycle after the strobe, i.e. now.
                pop_d      = mem_rd_data;
                rf_wr_en   = 1'b1;
                rf_addr    = SP_ADDR;
                rf_wr_data = sp_q + 8'd1;
                state_d    = S_POP_WB;
            end

            S_POP_WB: begin
                rf_wr_en   = 1'b1;
                rf_addr    = dst_q;
                rf_wr_data = pop_q;
                state_d    = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end

            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
// ============================================================================
//  Module   : tb_stack_ctrl
//  Purpose  : Randomized self-checking bench for stack_ctrl with a
//             transaction-level stack model and register-file/memory models.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stack_ctrl;

    localparam logic [3:0] SPA = 4'd15;
    localparam logic [7:0] TOP = 8'd127;
    localparam logic [7:0] BOT = 8'd125;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op_pop;
    logic [7:0] push_data;
    logic [3:0] pop_dst;
    logic [7:0] sp;
    logic       busy, done, err, rf_wr_en, mem_wr, mem_rd;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data, mem_addr, mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    stack_ctrl #(
        .SP_ADDR     (SPA),
        .STACK_TOP   (TOP),
        .STACK_BOTTOM(BOT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_pop     (op_pop),
        .push_data  (push_data),
        .pop_dst    (pop_dst),
        .sp         (sp),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rf_wr_en   (rf_wr_en),
        .rf_addr    (rf_addr),
        .rf_wr_data (rf_wr_data),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wr_data(mem_wr_data),
        .mem_rd     (mem_rd),
        .mem_rd_data(mem_rd_data)
    );

    // Environment: register file (SP in r15) and data memory driven by the DUT.
    logic [7:0] rf  [16];
    logic [7:0] mem [256];
    logic       cpu_we;
    logic [7:0] cpu_data;
    logic       mem_clr;

    assign sp = rf[15];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= (i == 15) ? TOP : 8'd0;
        end else if (rf_wr_en) begin
            rf[rf_addr] <= rf_wr_data;
        end else if (cpu_we) begin
            rf[15] <= cpu_data;
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wr_data;
        end
        if (mem_rd) mem_rd_data <= mem[mem_addr];
        else        mem_rd_data <= 8'd0;
    end

    // Reference model: expected output vector per cycle after an accept.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       rf_wr_en;
        logic [3:0] rf_addr;
        logic [7:0] rf_wr_data;
        logic [7:0] mem_addr;
        logic       mem_wr;
        logic [7:0] mem_wr_data;
        logic       mem_rd;
    } ov_t;

    ov_t        exp_q[$];
    logic [7:0] m_rf  [16];
    logic [7:0] m_mem [256];
    logic       cur_busy = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic model_accept(input bit pop, input logic [7:0] d, input logic [3:0] dst);
        logic [7:0] s;
        logic [7:0] v8;
        ov_t        v;
        s = m_rf[15];
        if (!pop && s < BOT || pop && s == TOP) begin
            v = '0; v.busy = 1'b1; v.done = 1'b1; v.err = 1'b1;
            exp_q.push_back(v);
        end else if (!pop) begin
            v = '0; v.busy = 1'b1; v.mem_wr = 1'b1; v.mem_addr = s; v.mem_wr_data = d;
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.rf_wr_en = 1'b1; v.rf_addr = SPA; v.rf_wr_data = s - 8'd1;
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
            m_mem[s]  = d;
            m_rf[SPA] = s - 8'd1;
        end else begin
            v8 = m_mem[8'(s + 8'd1)];
            v = '0; v.busy = 1'b1; v.mem_rd = 1'b1; v.mem_addr = s + 8'd1;
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.rf_wr_en = 1'b1; v.rf_addr = SPA; v.rf_wr_data = s + 8'd1;
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.rf_wr_en = 1'b1; v.rf_addr = dst; v.rf_wr_data = v8;
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
            m_rf[SPA] = s + 8'd1;
            m_rf[dst] = v8;
        end
    endtask

    // Advance one clock and compare every DUT output against the model.
    task automatic step();
        logic rs;
        ov_t  act;
        ov_t  exp_v;
        @(posedge clk);
        rs = rst;
        #1;
        if (rs) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) m_rf[i] = 8'd0;
            m_rf[15] = TOP;
        end
        exp_v = '0;
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        act = {busy, done, err, rf_wr_en, rf_addr, rf_wr_data,
               mem_addr, mem_wr, mem_wr_data, mem_rd};
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL outputs @%0t: got %09h expected %09h", $time, act, exp_v);
        end
        cur_busy = exp_v.busy;
    endtask

    task automatic lit(input string nm, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic drive(input bit st, input bit pop, input logic [7:0] d, input logic [3:0] dst);
        start     = st;
        op_pop    = pop;
        push_data = d;
        pop_dst   = dst;
        if (st && !cur_busy && !rst) model_accept(pop, d, dst);
        step();
        start = 1'b0;
    endtask

    task automatic cpu_sp(input logic [7:0] v);
        cpu_we   = 1'b1;
        cpu_data = v;
        m_rf[15] = v;
        step();
        cpu_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
        rst = 1'b1; mem_clr = 1'b1; start = 1'b0; op_pop = 1'b0;
        push_data = 8'd0; pop_dst = 4'd0; cpu_we = 1'b0; cpu_data = 8'd0;
        step(); step();
        rst = 1'b0; mem_clr = 1'b0;
        idle(1);
        lit("reset_busy", int'(busy), 0);

        // PUSH 0xA5 at sp=127
        drive(1'b1, 1'b0, 8'hA5, 4'd0);
        lit("push_memwr", int'(mem_wr), 1);
        lit("push_addr", int'(mem_addr), 127);
        lit("push_wdata", int'(mem_wr_data), 8'hA5);
        idle(1);
        lit("push_sp", int'(rf_wr_data), 126);
        idle(1);
        lit("push_done", int'({done, err}), 2);
        idle(1);

        // POP to r3 at sp=126
        drive(1'b1, 1'b1, 8'd0, 4'd3);
        lit("pop_addr", int'({mem_rd, mem_addr}), 9'h17F);
        idle(1);
        lit("pop_sp", int'(rf_wr_data), 127);
        idle(1);
        lit("pop_wb", int'({rf_addr, rf_wr_data}), 12'h3A5);
        idle(1);
        lit("pop_done", int'(done), 1);
        idle(1);

        // Underflow at sp=127
        drive(1'b1, 1'b1, 8'd0, 4'd2);
        lit("uflow", int'({done, err, mem_rd, rf_wr_en}), 4'b1100);
        idle(1);

        // Pushes down to the bottom, fourth overflows
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + k), 4'd0);
            if (k == 3) lit("oflow", int'({done, err, mem_wr}), 3'b110);
            idle(4);
        end
        lit("oflow_mem", int'(mem[124]), 0);
        lit("oflow_sp", int'(rf[15]), 124);

        // POP into SP itself: SP ends holding the popped value
        cpu_sp(8'd127);
        drive(1'b1, 1'b0, 8'h40, 4'd0);
        idle(4);
        drive(1'b1, 1'b1, 8'd0, 4'd15);
        idle(5);
        lit("pop_to_sp", int'(rf[15]), 8'h40);

        // Abort in PUSH_MEM with a stray start
        cpu_sp(8'd127);
        drive(1'b1, 1'b0, 8'h77, 4'd0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'd0, 4'd0);
        lit("abort_done", int'({busy, done}), 0);
        rst = 1'b0;
        idle(4);
        lit("abort_sp", int'(rf[15]), 127);
        lit("abort_mem", int'(mem[127]), 8'h77);

        // Randomized traffic, including starts while busy and CPU SP writes
        for (int n = 0; n < 2500; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                drive(1'b1, 1'($urandom), 8'($urandom), 4'($urandom));
            end else if (r == 5 && !cur_busy) begin
                case ($urandom_range(0, 3))
                    0:       cpu_sp(TOP);
                    1:       cpu_sp(8'($urandom_range(123, 127)));
                    2:       cpu_sp(8'($urandom));
                    default: cpu_sp(BOT);
                endcase
            end else begin
                idle(1);
            end
        end
        idle(6);
        for (int i = 0; i < 16; i++) lit($sformatf("rf%0d", i), int'(rf[i]), int'(m_rf[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
